clock_key_ctrl: RTL and testbench

//  Front-panel controller for the digital clock. Synchronises and debounces the two raw push-buttons.

---
 rtl/clock_key_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_clock_key_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_key_ctrl.sv
// Front-panel key controller for the digital clock.
// Synchronises and debounces the mode/add buttons, sequences the clock's set
// modes with one-cycle pulses, and owns the editable alarm time.
module clock_key_ctrl #(
    parameter int DEBOUNCE = 20,
    parameter int HOLD     = 500,
    parameter int REPEAT   = 200,
    parameter int TIMEOUT  = 10000,
    parameter int ALM_HR0  = 7,
    parameter int ALM_MIN0 = 0
) (
    input  logic        clk_1khz,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_add,
    input  logic        alarm_ringing,
    output logic        set_en,
    output logic        switch_pulse,
    output logic        add_pulse,
    output logic [31:0] alarm_set,
    output logic        disp_alarm,
    output logic [2:0]  mode
);

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int RP_W  = $clog2(((HOLD > REPEAT) ? HOLD : REPEAT) + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_MIN = 3'd1,
        SET_HR  = 3'd2,
        ALM_MIN = 3'd3,
        ALM_HR  = 3'd4
    } state_t;

    // Two-digit BCD increment with wrap to 00 after the given maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Binary 0..99 to two BCD digits, used for the reset alarm time.
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Index 0 is the mode key, index 1 is the add key.
    logic [1:0]      sync_p0, sync_p1;
    logic [1:0]      db, db_q;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state, state_n;
    logic            sw_n, add_n;
    logic [TO_W-1:0] tcnt, tcnt_n;
    logic [RP_W-1:0] rcnt, rcnt_n;
    logic            armed, armed_n;
    logic [7:0]      alm_hr, alm_hr_n;
    logic [7:0]      alm_min, alm_min_n;

    logic mode_evt, add_press, rpt_evt, add_evt, any_evt;

    // Two-flop synchronisers and consecutive-cycle debounce counters for both keys.
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++)
                db_cnt[i] <= '0;
        end else begin
            sync_p0 <= {key_add, key_mode};
            sync_p1 <= sync_p0;
            db_q    <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    db[i]     <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press events are debounced rising edges; releases generate nothing.
    assign mode_evt  = db[0] & ~db_q[0];
    assign add_press = db[1] & ~db_q[1];
    assign rpt_evt   = armed & db[1] & (rcnt == RP_W'(HOLD));
    assign add_evt   = add_press | rpt_evt;
    assign any_evt   = mode_evt | add_evt;

    // Next-state, pulse, auto-repeat, timeout and alarm-edit decisions.
    always_comb begin
        state_n   = state;
        sw_n      = 1'b0;
        add_n     = 1'b0;
        tcnt_n    = tcnt;
        rcnt_n    = rcnt;
        armed_n   = armed;
        alm_hr_n  = alm_hr;
        alm_min_n = alm_min;

        // Repeat timer runs only while add is held after an armed press.
        if (!db[1]) begin
            armed_n = 1'b0;
            rcnt_n  = '0;
        end else if (armed) begin
            rcnt_n = rpt_evt ? RP_W'(HOLD - REPEAT + 1) : rcnt + RP_W'(1);
        end

        unique case (state)
            RUN: begin
                if (any_evt && alarm_ringing) begin
                    sw_n = 1'b1;
                end else if (mode_evt) begin
                    state_n = SET_MIN;
                    sw_n    = 1'b1;
                end
            end
            SET_MIN: begin
                if (mode_evt) begin
                    state_n = SET_HR;
                    sw_n    = 1'b1;
                end else if (add_evt) begin
                    add_n = 1'b1;
                end
            end
            SET_HR: begin
                if (mode_evt) begin
                    state_n = ALM_MIN;
                    sw_n    = 1'b1;
                end else if (add_evt) begin
                    add_n = 1'b1;
                end
            end
            ALM_MIN: begin
                if (mode_evt)
                    state_n = ALM_HR;
                else if (add_evt)
                    alm_min_n = bcd_inc(alm_min, 8'h59);
            end
            ALM_HR: begin
                if (mode_evt)
                    state_n = RUN;
                else if (add_evt)
                    alm_hr_n = bcd_inc(alm_hr, 8'h23);
            end
            default: state_n = RUN;
        endcase

        // A fresh add press in an edit state arms the repeat timer; mode wins a tie.
        if (state != RUN && add_press && !mode_evt) begin
            armed_n = 1'b1;
            rcnt_n  = RP_W'(1);
        end

        // Inactivity timeout back to RUN; held at zero in RUN.
        if (state == RUN) begin
            tcnt_n = '0;
        end else if (any_evt) begin
            tcnt_n = '0;
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
            state_n = RUN;
            tcnt_n  = '0;
        end else begin
            tcnt_n = tcnt + TO_W'(1);
        end

        // Any state change cancels auto-repeat.
        if (state_n != state) begin
            armed_n = 1'b0;
            rcnt_n  = '0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            state        <= RUN;
            switch_pulse <= 1'b0;
            add_pulse    <= 1'b0;
            set_en       <= 1'b0;
            disp_alarm   <= 1'b0;
            tcnt         <= '0;
            rcnt         <= '0;
            armed        <= 1'b0;
            alm_hr       <= to_bcd(ALM_HR0);
            alm_min      <= to_bcd(ALM_MIN0);
        end else begin
            state        <= state_n;
            switch_pulse <= sw_n;
            add_pulse    <= add_n;
            set_en       <= (state_n == SET_MIN) || (state_n == SET_HR);
            disp_alarm   <= (state_n == ALM_MIN) || (state_n == ALM_HR);
            tcnt         <= tcnt_n;
            rcnt         <= rcnt_n;
            armed        <= armed_n;
            alm_hr       <= alm_hr_n;
            alm_min      <= alm_min_n;
        end
    end

    assign mode      = 3'(state);
    assign alarm_set = {alm_hr, 4'hE, alm_min, 4'hE, 8'h00};

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Scoreboard bench for clock_key_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the DUT shows a pulse or change.
module tb_clock_key_ctrl;

    localparam int LAT    = 23;   // raw key rise to registered output, in cycles
    localparam int HOLD_C = 25;   // cycles a clean press is held
    localparam int GAP_C  = 25;   // cycles between clean presses

    logic        clk_1khz = 1'b0;
    logic        rst = 1'b1;
    logic        key_mode = 1'b0;
    logic        key_add = 1'b0;
    logic        alarm_ringing = 1'b0;
    logic        set_en, switch_pulse, add_pulse, disp_alarm;
    logic [31:0] alarm_set;
    logic [2:0]  mode;

    clock_key_ctrl #(
        .DEBOUNCE(20), .HOLD(500), .REPEAT(200), .TIMEOUT(10000),
        .ALM_HR0(7), .ALM_MIN0(0)
    ) dut (
        .clk_1khz(clk_1khz), .rst(rst), .key_mode(key_mode), .key_add(key_add),
        .alarm_ringing(alarm_ringing), .set_en(set_en), .switch_pulse(switch_pulse),
        .add_pulse(add_pulse), .alarm_set(alarm_set), .disp_alarm(disp_alarm), .mode(mode)
    );

    always #5 clk_1khz = ~clk_1khz;

    int cyc = 0;
    always @(posedge clk_1khz) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  mode;
        logic        sw;
        logic        add;
        logic        set_en;
        logic        disp;
        logic [31:0] alarm;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [2:0]  p_mode;
    logic        p_set_en, p_disp;
    logic [31:0] p_alarm;
    logic [31:0] cur_alarm;
    int          k;

    function automatic logic [31:0] alm(input int h, input int m);
        logic [7:0] hb, mb;
        hb = {4'(h / 10), 4'(h % 10)};
        mb = {4'(m / 10), 4'(m % 10)};
        return {hb, 4'hE, mb, 4'hE, 8'h00};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_1khz);
        #1;
    endtask

    task automatic expect_at(input int c, input logic [2:0] m, input logic sw,
                             input logic ad, input logic [31:0] al);
        exp_t e;
        e.cyc    = c;
        e.mode   = m;
        e.sw     = sw;
        e.add    = ad;
        e.set_en = (m == 3'd1) || (m == 3'd2);
        e.disp   = (m == 3'd3) || (m == 3'd4);
        e.alarm  = al;
        exp_q.push_back(e);
    endtask

    // key: 0 = mode, 1 = add, 2 = both together
    task automatic press(input int key, input logic [2:0] m, input logic sw,
                         input logic ad, input bit has_exp = 1'b1);
        if (has_exp)
            expect_at(cyc + LAT, m, sw, ad, cur_alarm);
        if (key == 0 || key == 2) key_mode = 1'b1;
        if (key == 1 || key == 2) key_add = 1'b1;
        step(HOLD_C);
        key_mode = 1'b0;
        key_add  = 1'b0;
        step(GAP_C);
    endtask

    // Output-event monitor.
    always @(negedge clk_1khz) begin : mon
        exp_t e;
        if (mon_en) begin
            if (switch_pulse || add_pulse || mode !== p_mode || set_en !== p_set_en ||
                disp_alarm !== p_disp || alarm_set !== p_alarm) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got cyc=%0d mode=%0d sw=%b add=%b set_en=%b disp=%b alarm=%h, want no output",
                             cyc, mode, switch_pulse, add_pulse, set_en, disp_alarm, alarm_set);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || mode !== e.mode || switch_pulse !== e.sw ||
                        add_pulse !== e.add || set_en !== e.set_en ||
                        disp_alarm !== e.disp || alarm_set !== e.alarm) begin
                        errors++;
                        $display("FAIL out_event: got cyc=%0d mode=%0d sw=%b add=%b set_en=%b disp=%b alarm=%h, want cyc=%0d mode=%0d sw=%b add=%b set_en=%b disp=%b alarm=%h",
                                 cyc, mode, switch_pulse, add_pulse, set_en, disp_alarm, alarm_set,
                                 e.cyc, e.mode, e.sw, e.add, e.set_en, e.disp, e.alarm);
                    end
                end
            end
            p_mode   = mode;
            p_set_en = set_en;
            p_disp   = disp_alarm;
            p_alarm  = alarm_set;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got cyc=%0d, want finish before 60000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(3);
        checks++;
        if (mode !== 3'd0 || switch_pulse !== 1'b0 || add_pulse !== 1'b0 || set_en !== 1'b0 ||
            disp_alarm !== 1'b0 || alarm_set !== 32'h07E00E00) begin
            errors++;
            $display("FAIL reset_state: got mode=%0d sw=%b add=%b set_en=%b disp=%b alarm=%h, want 0 0 0 0 0 07e00e00",
                     mode, switch_pulse, add_pulse, set_en, disp_alarm, alarm_set);
        end
        rst       = 1'b0;
        cur_alarm = 32'h07E00E00;
        p_mode    = 3'd0;
        p_set_en  = 1'b0;
        p_disp    = 1'b0;
        p_alarm   = 32'h07E00E00;
        mon_en    = 1'b1;
        step(2);

        // Mode cycle
        press(0, 3'd1, 1'b1, 1'b0);
        press(0, 3'd2, 1'b1, 1'b0);
        press(0, 3'd3, 1'b1, 1'b0);
        press(0, 3'd4, 1'b0, 1'b0);
        press(0, 3'd0, 1'b0, 1'b0);

        // Alarm hour wrap
        press(0, 3'd1, 1'b1, 1'b0);
        press(0, 3'd2, 1'b1, 1'b0);
        press(0, 3'd3, 1'b1, 1'b0);
        press(0, 3'd4, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            cur_alarm = (i == 17) ? 32'h00E00E00 : alm((7 + i) % 24, 0);
            press(1, 3'd4, 1'b0, 1'b0);
        end
        press(0, 3'd0, 1'b0, 1'b0);

        // Alarm minute wrap
        press(0, 3'd1, 1'b1, 1'b0);
        press(0, 3'd2, 1'b1, 1'b0);
        press(0, 3'd3, 1'b1, 1'b0);
        for (int i = 1; i <= 61; i++) begin
            cur_alarm = (i == 61) ? 32'h00E01E00 : alm(0, i % 60);
            press(1, 3'd3, 1'b0, 1'b0);
        end
        press(0, 3'd4, 1'b0, 1'b0);
        press(0, 3'd0, 1'b0, 1'b0);

        // Bounce in SET_MIN: one add_pulse from the final rise only
        press(0, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            key_add = (i % 2 == 0);
            step(5);
        end
        key_add = 1'b1;
        expect_at(cyc + LAT, 3'd1, 1'b0, 1'b1, cur_alarm);
        step(40);
        key_add = 1'b0;
        step(GAP_C);

        // Auto-repeat in SET_HR: press plus five repeats
        press(0, 3'd2, 1'b1, 1'b0);
        k = cyc;
        expect_at(k + LAT, 3'd2, 1'b0, 1'b1, cur_alarm);
        for (int j = 0; j < 5; j++)
            expect_at(k + LAT + 500 + 200 * j, 3'd2, 1'b0, 1'b1, cur_alarm);
        key_add = 1'b1;
        step(1400);
        key_add = 1'b0;
        step(100);

        // Timeout from ALM_MIN, no pulse
        k = cyc;
        press(0, 3'd3, 1'b1, 1'b0);
        expect_at(k + LAT + 10000, 3'd0, 1'b0, 1'b0, cur_alarm);
        step(10000);

        // Simultaneous mode+add in SET_MIN: mode wins
        press(0, 3'd1, 1'b1, 1'b0);
        press(2, 3'd2, 1'b1, 1'b0);
        press(0, 3'd3, 1'b1, 1'b0);
        press(0, 3'd4, 1'b0, 1'b0);
        press(0, 3'd0, 1'b0, 1'b0);

        // Ringing silence in RUN
        alarm_ringing = 1'b1;
        press(1, 3'd0, 1'b1, 1'b0);
        press(0, 3'd0, 1'b1, 1'b0);
        alarm_ringing = 1'b0;
        step(5);

        // Reset in the middle of an auto-repeat
        press(0, 3'd1, 1'b1, 1'b0);
        k = cyc;
        expect_at(k + LAT, 3'd1, 1'b0, 1'b1, cur_alarm);
        expect_at(k + LAT + 500, 3'd1, 1'b0, 1'b1, cur_alarm);
        key_add = 1'b1;
        step(600);
        rst       = 1'b1;
        cur_alarm = 32'h07E00E00;
        expect_at(cyc + 1, 3'd0, 1'b0, 1'b0, cur_alarm);
        step(1);
        rst = 1'b0;
        step(100);
        key_add = 1'b0;
        step(100);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, want 0 (next due cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
